cgra_sram_bank_arbiter: RTL

Shares one single-port CGRA SRAM bank between NumPorts requesters, such as the CGRA datapath load/store unit and the host bus. Arbitration is round-robin. Grants are issued in the same cycle as the request, and the response is returned one cycle later. The block also sequences the bank's retention mode with a sleep/wake handshake: it drains the in-flight access before retention and waits a programmable settle time on wake. It sits directly in front of the bank macro wrapper.

---
 rtl/cgra_sram_bank_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cgra_sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port CGRA SRAM bank between
// NumPorts requesters. Grants are combinational and the response is
// returned one cycle after the grant. A sleep/wake sequencer drains the
// bank before it enters retention and holds grants off for a settle time
// after it leaves retention.
module cgra_sram_bank_arbiter #(
  parameter int NumPorts   = 2,
  parameter int NumWords   = 1024,
  parameter int WakeCycles = 4,
  parameter int AddrWidth  = $clog2(NumWords)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumPorts-1:0]           req_i,
  input  logic [NumPorts-1:0]           we_i,
  input  logic [NumPorts*AddrWidth-1:0] addr_i,
  input  logic [NumPorts*32-1:0]        wdata_i,
  input  logic [NumPorts*4-1:0]         be_i,
  output logic [NumPorts-1:0]           gnt_o,
  output logic [NumPorts-1:0]           rvalid_o,
  output logic [31:0]                   rdata_o,
  input  logic                          sleep_req_i,
  output logic                          sleep_ack_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_be_o,
  input  logic [31:0]                   mem_rdata_i,
  output logic                          set_retentive_o
);

  localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RET    = 2'd2,
    ST_WAKE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [PtrW-1:0]     r_ptr;
  logic [NumPorts-1:0] r_rvalid;
  logic [7:0]          r_wake_cnt;
  logic                r_sleep_ack;
  logic                r_set_ret;

  logic                w_arb_en;
  logic                w_found;
  logic                w_hit;
  logic [NumPorts-1:0] w_gnt;
  logic [PtrW-1:0]     w_next_ptr;
  logic                w_mem_we;
  logic [AddrWidth-1:0] w_mem_addr;
  logic [31:0]         w_mem_wdata;
  logic [3:0]          w_mem_be;

  // Round-robin scan: offsets are visited in order starting at the pointer,
  // so the first requesting port at the smallest offset wins. Grants are
  // only possible in ACTIVE with no sleep request, which gives sleep priority.
  always_comb begin
    w_arb_en   = (r_state == ST_ACTIVE) && !sleep_req_i;
    w_gnt      = '0;
    w_found    = 1'b0;
    w_hit      = 1'b0;
    w_next_ptr = r_ptr;
    for (int off = 0; off < NumPorts; off++) begin
      for (int p = 0; p < NumPorts; p++) begin
        w_hit      = w_arb_en && !w_found && req_i[p] &&
                     (r_ptr == PtrW'((p + NumPorts - off) % NumPorts));
        w_gnt[p]   = w_gnt[p] | w_hit;
        w_next_ptr = w_hit ? PtrW'((p + 1) % NumPorts) : w_next_ptr;
        w_found    = w_found | w_hit;
      end
    end
  end

  // Payload mux: AND-OR selection by the one-hot grant, so idle cycles
  // drive all-zero data towards the bank.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = 32'd0;
    w_mem_be    = 4'd0;
    for (int p = 0; p < NumPorts; p++) begin
      w_mem_we    = w_mem_we | (we_i[p] & w_gnt[p]);
      w_mem_addr  = w_mem_addr | (addr_i[p*AddrWidth +: AddrWidth] & {AddrWidth{w_gnt[p]}});
      w_mem_wdata = w_mem_wdata | (wdata_i[p*32 +: 32] & {32{w_gnt[p]}});
      w_mem_be    = w_mem_be | (be_i[p*4 +: 4] & {4{w_gnt[p]}});
    end
  end

  assign gnt_o           = w_gnt;
  assign mem_req_o       = |w_gnt;
  assign mem_we_o        = w_mem_we;
  assign mem_addr_o      = w_mem_addr;
  assign mem_wdata_o     = w_mem_wdata;
  assign mem_be_o        = w_mem_be;
  assign rvalid_o        = r_rvalid;
  assign rdata_o         = mem_rdata_i;
  assign sleep_ack_o     = r_sleep_ack;
  assign set_retentive_o = r_set_ret;

  // Retention sequencer, round-robin pointer and response register. The
  // retention outputs are registered and change on entry to RET / WAKE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_ACTIVE;
      r_ptr       <= '0;
      r_rvalid    <= '0;
      r_wake_cnt  <= 8'd0;
      r_sleep_ack <= 1'b0;
      r_set_ret   <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_ptr    <= w_next_ptr;
      case (r_state)
        ST_ACTIVE: begin
          if (sleep_req_i) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_DRAIN: begin
          // The bank is idle by now; any last response leaves this cycle.
          r_state     <= ST_RET;
          r_set_ret   <= 1'b1;
          r_sleep_ack <= 1'b1;
        end
        ST_RET: begin
          if (!sleep_req_i) begin
            r_state     <= ST_WAKE;
            r_wake_cnt  <= 8'(WakeCycles);
            r_set_ret   <= 1'b0;
            r_sleep_ack <= 1'b0;
          end else begin
            r_state <= ST_RET;
          end
        end
        ST_WAKE: begin
          // Sleep requests here are ignored; ACTIVE picks them up at once.
          if (r_wake_cnt <= 8'd1) begin
            r_state    <= ST_ACTIVE;
            r_wake_cnt <= 8'd0;
          end else begin
            r_wake_cnt <= r_wake_cnt - 8'd1;
          end
        end
        default: begin
          r_state     <= ST_ACTIVE;
          r_wake_cnt  <= 8'd0;
          r_set_ret   <= 1'b0;
          r_sleep_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
